mem_req_queue: RTL and testbench
================================

Name: mem_req_queue

Overview:
- CPU-side request buffer directly upstream of the cache/DRAM top.
- Accepts load/store requests from the CPU memory stage with a valid/ready handshake and queues them in order.
- Issues queued requests one at a time on the addr_dram/din_dram/rw_dram/valid_dram interface and holds each until ready_dram.
- Returns read data to the CPU as a one-cycle response pulse; writes complete without a response.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- ADDR_W, 27, request address width; matches addr_dram.
- DATA_W, 32, data width; matches din_dram/dout_dram.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  queue can accept a request.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data; ignored for reads.
- req_rw  in  1  1 = write, 0 = read.
- resp_valid  out  1  one-cycle pulse: read data valid.
- resp_rdata  out  DATA_W  read data; held until the next resp_valid.
- addr_dram  out  ADDR_W  to cache top.
- din_dram  out  DATA_W  to cache top.
- rw_dram  out  1  to cache top.
- valid_dram  out  1  request strobe to cache top.
- dout_dram  in  DATA_W  read data from cache top.
- ready_dram  in  1  completion strobe from cache top.
- busy  out  1  queue non-empty or request in flight.

Behaviour:
- Reset: all outputs 0 except req_ready = 1; queue emptied; FSM set to IDLE.
- Enqueue occurs when req_valid && req_ready.
  - req_ready = !full, computed from registered count only. A simultaneous pop never frees a slot in the same cycle.
  - Count width is clog2(DEPTH+1).
  - Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if the queue is non-empty, latch the head entry into the addr_dram/din_dram/rw_dram registers, set valid_dram = 1, go to ISSUE. This costs 1 cycle minimum from enqueue to valid_dram.
  - ISSUE: addr/din/rw/valid are held stable. When ready_dram = 1 is sampled, pop the head, clear valid_dram, go to GAP.
    - Read: capture dout_dram into resp_rdata in that same cycle; resp_valid = 1 on the next cycle, for exactly 1 cycle.
  - GAP: exactly one cycle with valid_dram = 0, then go to IDLE. Between back-to-back requests, valid_dram is always low for at least 2 cycles (GAP + IDLE).
- ready_dram is ignored outside ISSUE.
- dout_dram is sampled only on the ready_dram cycle.
- Requests complete in enqueue order; only one request is ever outstanding.
- An enqueue in the same cycle as a pop is legal when not full; the count is unchanged.
- busy = (count != 0) || (state != IDLE).
- Reset mid-operation: the queue is flushed, valid_dram drops next cycle, the in-flight request is abandoned and gets no resp_valid. The cache top must share the same rst.
- While full, further req_valid is back-pressured: no drop, no overwrite.

Optional Feature:
- Macro: MEM_REQ_PERF_EN.
- With the macro defined, add outputs:
  - perf_reqs (32): count of accepted requests.
  - perf_stall (32): count of cycles with req_valid && !req_ready.
  - perf_wait (32): count of cycles in ISSUE.
  - All three clear on rst and saturate at all-ones.
- Without the macro: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Single read:
  - Stimulus: enqueue read addr 0x0000100; cache model asserts ready_dram 3 cycles after valid_dram with dout_dram = 0xDEADBEEF.
  - Required: valid_dram held 3 cycles with addr stable; resp_valid pulses once with resp_rdata = 0xDEADBEEF.
- Write then read same address:
  - Stimulus: write 0x12345678 to 0x40, then read 0x40; model returns the stored data.
  - Required: rw_dram = 1 then 0; no resp_valid for the write; exactly one resp_valid with 0x12345678.
- Fill to full:
  - Stimulus: stall ready_dram, present 6 back-to-back requests.
  - Required: req_ready drops after 4 accepted; remaining requests held; after completions, all 6 issued in order with no loss.
- Wrap-around:
  - Stimulus: 10 sequential reads at addresses 0..9, model returns data = addr + 0x100.
  - Required: responses 0x100..0x109 in order; valid_dram low ≥2 cycles between issues.
- Reset mid-ISSUE:
  - Stimulus: 3 queued, rst asserted while valid_dram = 1.
  - Required: next cycle valid_dram = 0, busy = 0, req_ready = 1; no resp_valid afterwards.
- With MEM_REQ_PERF_EN:
  - Stimulus: run the fill-to-full scenario.
  - Required: perf_reqs = 6; perf_stall equals the counted back-pressure cycles.

Source files
------------

// File: rtl/mem_req_queue_if.sv
// CPU request/response and cache-top request bus of the memory request queue.
// slave = the queue itself, master = whatever drives it (CPU stage plus cache top).
interface mem_req_queue_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_rw;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] addr_dram;
  logic [DATA_W-1:0] din_dram;
  logic              rw_dram;
  logic              valid_dram;
  logic [DATA_W-1:0] dout_dram;
  logic              ready_dram;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_rw, dout_dram, ready_dram,
    output req_ready, resp_valid, resp_rdata, addr_dram, din_dram, rw_dram,
           valid_dram, busy
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_rw, dout_dram, ready_dram,
    input  req_ready, resp_valid, resp_rdata, addr_dram, din_dram, rw_dram,
           valid_dram, busy
  );
endinterface

// File: rtl/mem_req_queue.sv
// In-order CPU memory request queue that issues one request at a time to the cache top.
// Optional MEM_REQ_PERF_EN adds saturating perf_reqs / perf_stall / perf_wait counters.
module mem_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  mem_req_queue_if.slave        bus
`ifdef MEM_REQ_PERF_EN
  ,
  output logic [31:0]           perf_reqs,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_wait
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  // Queue storage carries no reset; only pointers and count define its contents.
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_rw;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  state_t            state;
  logic [ADDR_W-1:0] addr_dram_r;
  logic [DATA_W-1:0] din_dram_r;
  logic              rw_dram_r;
  logic              valid_dram_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_rdata_r;

  logic full;
  logic push;
  logic pop;

  // Ready comes from the registered count alone, so a same-cycle pop never frees a slot.
  assign full = (count == CNT_W'(DEPTH));
  assign push = bus.req_valid && !full;
  assign pop  = (state == ISSUE) && bus.ready_dram;

  assign bus.req_ready  = !full;
  assign bus.busy       = (count != '0) || (state != IDLE);
  assign bus.addr_dram  = addr_dram_r;
  assign bus.din_dram   = din_dram_r;
  assign bus.rw_dram    = rw_dram_r;
  assign bus.valid_dram = valid_dram_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;

  always_ff @(posedge sys_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.req_addr;
      q_data[wr_ptr] <= bus.req_wdata;
      q_rw[wr_ptr]   <= bus.req_rw;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The in-flight entry stays at the head until ready_dram, so rd_ptr always names it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_dram_r  <= '0;
      din_dram_r   <= '0;
      rw_dram_r    <= 1'b0;
      valid_dram_r <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
    end else begin
      resp_valid_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            addr_dram_r  <= q_addr[rd_ptr];
            din_dram_r   <= q_data[rd_ptr];
            rw_dram_r    <= q_rw[rd_ptr];
            valid_dram_r <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.ready_dram) begin
            valid_dram_r <= 1'b0;
            state        <= GAP;
            if (!rw_dram_r) begin
              resp_rdata_r <= bus.dout_dram;
              resp_valid_r <= 1'b1;
            end
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          valid_dram_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_REQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      perf_reqs  <= '0;
      perf_stall <= '0;
      perf_wait  <= '0;
    end else begin
      if (push)                  perf_reqs  <= sat_inc(perf_reqs);
      if (bus.req_valid && full) perf_stall <= sat_inc(perf_stall);
      if (state == ISSUE)        perf_wait  <= sat_inc(perf_wait);
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Randomised bench for mem_req_queue: queue-based reference model plus a small cache-top responder.
module tb_mem_req_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rdata;
  } req_t;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  mem_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_REQ_PERF_EN
  logic [31:0] perf_reqs, perf_stall, perf_wait;
  mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .bus(bus),
    .perf_reqs(perf_reqs), .perf_stall(perf_stall), .perf_wait(perf_wait)
  );
`else
  mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .bus(bus)
  );
`endif

  req_t              mq[$];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] cmem    [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] resp_log[$];
  logic [ADDR_W-1:0] issue_addr[$];
  logic              issue_rw[$];

  int n_vec = 0, n_err = 0;
  bit v_before = 1'b0, exp_ready_before = 1'b1, acc_last = 1'b0;
  bit stall = 1'b0, rand_stall = 1'b0;
  int since_cpl = 10, vcnt = 0, cur_lat = 1, fixed_lat = 0, last_hold = 0, resp_cnt = 0;
  logic [DATA_W-1:0] last_resp = '0;
  logic              cap_rw = 1'b0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic [DATA_W-1:0] cap_data = '0;
  int m_reqs = 0, m_stall = 0, m_wait = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + 32'h100;
  endfunction

  // One clock: account for the edge with the pre-edge inputs, check outputs, then drive the cache side.
  task automatic tick();
    bit acc, cpl, in_rst, exp_v, exp_rv;
    int out_before, since_before;
    req_t e;
    logic [DATA_W-1:0] exp_rd;
    in_rst       = rst;
    out_before   = mq.size();
    since_before = since_cpl;
    acc = !in_rst && bus.req_valid && exp_ready_before;
    cpl = !in_rst && bus.ready_dram && v_before;
    if (in_rst) begin
      m_reqs = 0; m_stall = 0; m_wait = 0;
    end else begin
      if (acc) m_reqs++;
      if (bus.req_valid && !exp_ready_before) m_stall++;
      if (v_before) m_wait++;
    end
    exp_rd = '0;
    @(posedge sys_clk);
    #1;
    if (in_rst) begin
      mq.delete();
      ref_mem   = cmem;
      since_cpl = 10;
      last_resp = '0;
      chk("rst_valid_dram", bus.valid_dram, 0);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_addr_dram", bus.addr_dram, 0);
    end else begin
      exp_rv = 1'b0;
      if (cpl) begin
        e = mq.pop_front();
        if (cap_rw) cmem[cap_addr] = cap_data;
        if (!e.rw) begin
          exp_rv = 1'b1;
          exp_rd = e.rdata;
        end
        since_cpl = 0;
      end else if (since_cpl < 10) begin
        since_cpl++;
      end
      if (acc) begin
        e.rw = bus.req_rw; e.addr = bus.req_addr; e.data = bus.req_wdata;
        e.rdata = ref_mem.exists(e.addr) ? ref_mem[e.addr] : dflt(e.addr);
        if (e.rw) ref_mem[e.addr] = e.data;
        mq.push_back(e);
      end
      chk("resp_valid", bus.resp_valid, exp_rv);
      if (exp_rv) last_resp = exp_rd;
      if (bus.resp_valid) begin
        resp_cnt++;
        resp_log.push_back(bus.resp_rdata);
      end
      chk("resp_rdata", bus.resp_rdata, last_resp);
      chk("req_ready", bus.req_ready, mq.size() < DEPTH);
      chk("busy", bus.busy, (mq.size() != 0) || cpl);
      exp_v = v_before ? !cpl : (since_before >= 1 && out_before > 0);
      chk("valid_dram", bus.valid_dram, exp_v);
      if (bus.valid_dram && mq.size() > 0) begin
        chk("addr_dram", bus.addr_dram, mq[0].addr);
        chk("rw_dram", bus.rw_dram, mq[0].rw);
        if (mq[0].rw) chk("din_dram", bus.din_dram, mq[0].data);
      end
    end
`ifdef MEM_REQ_PERF_EN
    chk("perf_reqs", perf_reqs, m_reqs);
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_wait", perf_wait, m_wait);
`endif
    if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    if (bus.valid_dram) begin
      if (vcnt == 0) begin
        cur_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        issue_addr.push_back(bus.addr_dram);
        issue_rw.push_back(bus.rw_dram);
      end
      vcnt++;
      if (vcnt >= cur_lat && !stall) begin
        bus.ready_dram = 1'b1;
        cap_rw = bus.rw_dram; cap_addr = bus.addr_dram; cap_data = bus.din_dram;
        bus.dout_dram = cap_rw ? $urandom :
                        (cmem.exists(cap_addr) ? cmem[cap_addr] : dflt(cap_addr));
      end else begin
        bus.ready_dram = 1'b0;
        bus.dout_dram  = $urandom;
      end
    end else begin
      if (vcnt > 0) last_hold = vcnt;
      vcnt = 0;
      bus.ready_dram = ($urandom_range(0, 3) == 0);
      bus.dout_dram  = $urandom;
    end
    v_before         = bus.valid_dram;
    exp_ready_before = (mq.size() < DEPTH);
    acc_last         = acc;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic send(input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (acc_last) break;
    end
    if (!acc_last) chk("send_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == 0 && since_cpl >= 2) break;
      tick();
    end
    if (!(mq.size() == 0 && since_cpl >= 2)) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int r0, i0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ready_dram = 1'b0; bus.dout_dram = '0;
    do_reset(2);

    // Single read with a three-cycle cache latency
    cmem[27'h100] = 32'hDEADBEEF;
    ref_mem[27'h100] = 32'hDEADBEEF;
    fixed_lat = 3;
    r0 = resp_cnt;
    send(1'b0, 27'h100, $urandom);
    chk("t1_lat0", bus.valid_dram, 0);
    tick();
    chk("t1_lat1", bus.valid_dram, 1);
    chk("t1_addr", bus.addr_dram, 27'h100);
    drain();
    chk("t1_hold", last_hold, 3);
    chk("t1_resp_cnt", resp_cnt - r0, 1);
    chk("t1_rdata", resp_log[$], 32'hDEADBEEF);
    fixed_lat = 0;

    // Write then read back the same address
    r0 = resp_cnt; i0 = issue_rw.size();
    send(1'b1, 27'h40, 32'h12345678);
    send(1'b0, 27'h40, $urandom);
    drain();
    chk("t2_issues", issue_rw.size() - i0, 2);
    chk("t2_rw_first", issue_rw[i0], 1);
    chk("t2_rw_second", issue_rw[i0+1], 0);
    chk("t2_resp_cnt", resp_cnt - r0, 1);
    chk("t2_rdata", resp_log[$], 32'h12345678);

    // Fill to full with the cache stalled, six requests presented back to back
    do_reset(1);
    stall = 1'b1;
    r0 = resp_cnt; i0 = issue_addr.size();
    for (int k = 0; k < 4; k++) send(1'b0, 27'(32'h200 + k), $urandom);
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 27'h204;
    repeat (5) tick();
    chk("t3_full_ready", bus.req_ready, 0);
    chk("t3_held", mq.size(), 4);
    stall = 1'b0;
    send(1'b0, 27'h204, $urandom);
    send(1'b0, 27'h205, $urandom);
    drain();
    chk("t3_resp_cnt", resp_cnt - r0, 6);
    for (int k = 0; k < 6; k++) chk("t3_order", issue_addr[i0+k], 27'(32'h200 + k));
`ifdef MEM_REQ_PERF_EN
    chk("t3_perf_reqs", perf_reqs, 6);
    chk("t3_perf_stall", perf_stall, m_stall);
`endif

    // Ten sequential reads to exercise pointer wrap
    r0 = resp_cnt;
    for (int k = 0; k < 10; k++) send(1'b0, 27'(k), $urandom);
    drain();
    chk("t4_resp_cnt", resp_cnt - r0, 10);
    for (int k = 0; k < 10; k++) chk("t4_rdata", resp_log[r0+k], 32'h100 + k);

    // Reset while a request is being issued
    stall = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b0, 27'(32'h300 + k), $urandom);
    for (int k = 0; k < 20 && !bus.valid_dram; k++) tick();
    chk("t5_issuing", bus.valid_dram, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", bus.valid_dram, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_ready", bus.req_ready, 1);
    stall = 1'b0;
    r0 = resp_cnt; i0 = issue_addr.size();
    repeat (8) tick();
    chk("t5_no_resp", resp_cnt - r0, 0);
    chk("t5_no_issue", issue_addr.size() - i0, 0);

    // Random traffic with a small address set so reads hit earlier writes
    rand_stall = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send($urandom_range(0, 1) == 1, 27'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_stall = 1'b0;
    stall = 1'b0;
    drain();
    chk("t6_empty", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
